// File: rtl/tx_port_scheduler.sv
// tx_port_scheduler: round-robin arbiter sharing one serial TX lane among N_REQ frame sources,
// holding off DEPTH+IFG cycles after each launch so the line idles between frames.
module tx_port_scheduler #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 16,
  parameter int IFG   = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DEPTH-1:0]   req_frame,
  input  logic [N_REQ-1:0]         port_en,
  output logic [N_REQ-1:0]         grant,
  output logic [DEPTH-1:0]         tx_frame,
  output logic                     frame_tx_valid,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [CNT_W-1:0]         tx_count
);
  localparam int PW   = $clog2(N_REQ);
  localparam int HOLD = DEPTH + IFG;
  localparam int HW   = $clog2(HOLD + 1);

  typedef enum logic {IDLE, XMIT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, last_q, last_d, win;
  logic [HW-1:0]     hold_q, hold_d;
  logic [N_REQ-1:0]  grant_q, grant_d, eff;
  logic [DEPTH-1:0]  frame_q, frame_d;
  logic              ftv_q, ftv_d, found;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PW:0]       cand;

  always_comb begin
    eff   = req & port_en;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    // first effective request at or above the pointer, wrapping modulo N_REQ
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      cand = (cand >= (PW+1)'(N_REQ)) ? cand - (PW+1)'(N_REQ) : cand;
      if (!found && eff[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = '0;
    ftv_d   = 1'b0;
    frame_d = frame_q;
    last_d  = last_q;
    count_d = count_q;
    if (state_q == IDLE && found) begin
      state_d = XMIT;
      grant_d = N_REQ'(1) << win;
      ftv_d   = 1'b1;
      frame_d = req_frame[int'(win)*DEPTH +: DEPTH];
      last_d  = win;
      ptr_d   = (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;
      hold_d  = HW'(HOLD);
      count_d = (&count_q) ? count_q : count_q + 1'b1;
    end else if (state_q == XMIT) begin
      state_d = (hold_q == '0) ? IDLE : XMIT;
      hold_d  = (hold_q == '0) ? hold_q : hold_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      ftv_q   <= 1'b0;
      frame_q <= '0;
      last_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      ftv_q   <= ftv_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign grant          = grant_q;
  assign tx_frame       = frame_q;
  assign frame_tx_valid = ftv_q;
  assign busy           = (state_q == XMIT);
  assign last_grant     = last_q;
  assign tx_count       = count_q;
endmodule

// File: tb/tb_tx_port_scheduler.sv
// tb_tx_port_scheduler: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a cycle-level behavioural model.
module tb_tx_port_scheduler;
  localparam int N = 4, D = 16, G = 2;

  logic          clk = 1'b0, rst = 1'b1;
  logic [N-1:0]  req = '0, port_en = '0;
  logic [N*D-1:0] req_frame = '0;
  logic [N-1:0]  grant, grant2;
  logic [D-1:0]  tx_frame, tx_frame2;
  logic          ftv, ftv2, busy, busy2;
  logic [1:0]    last_grant, last_grant2;
  logic [15:0]   tx_count;
  logic [1:0]    tx_count2;

  int n_cmp = 0, n_bad = 0;

  tx_port_scheduler #(.N_REQ(N), .DEPTH(D), .IFG(G), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_frame(req_frame), .port_en(port_en),
    .grant(grant), .tx_frame(tx_frame), .frame_tx_valid(ftv), .busy(busy),
    .last_grant(last_grant), .tx_count(tx_count));

  tx_port_scheduler #(.N_REQ(N), .DEPTH(D), .IFG(G), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .req_frame(req_frame), .port_en(port_en),
    .grant(grant2), .tx_frame(tx_frame2), .frame_tx_valid(ftv2), .busy(busy2),
    .last_grant(last_grant2), .tx_count(tx_count2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: busy_left counts remaining busy cycles after a launch (DEPTH+IFG+1)
  int         m_ptr = 0, busy_left = 0, m_last = 0, m_count = 0, m_count2 = 0;
  logic [N-1:0] m_grant = '0;
  logic       m_ftv = 1'b0;
  logic [D-1:0] m_frame = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; busy_left = 0; m_last = 0; m_count = 0; m_count2 = 0;
      m_grant = '0; m_ftv = 1'b0; m_frame = '0;
    end else begin
      logic [N-1:0] eff;
      int w;
      eff = req & port_en;
      w = -1;
      m_grant = '0;
      m_ftv = 1'b0;
      if (busy_left == 0) begin
        for (int k = 0; k < N; k++)
          if (w < 0 && eff[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end else busy_left--;
      if (w >= 0) begin
        m_grant = N'(1) << w;
        m_ftv = 1'b1;
        m_frame = req_frame[w*D +: D];
        m_last = w;
        m_ptr = (w + 1) % N;
        busy_left = D + G + 1;
        m_count = (m_count == 65535) ? m_count : m_count + 1;
        m_count2 = (m_count2 == 3) ? 3 : m_count2 + 1;
      end
    end
  end

  always @(posedge clk) begin
    #3;
    chk("grant", grant, m_grant);
    chk("frame_tx_valid", ftv, m_ftv);
    chk("tx_frame", tx_frame, m_frame);
    chk("busy", busy, busy_left > 0);
    chk("last_grant", last_grant, m_last);
    chk("tx_count", tx_count, m_count);
    chk("tx_count_sat", tx_count2, m_count2);
  end

  int exp_g[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
  int exp_sat[5] = '{1, 2, 3, 3, 3};

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_count", tx_count, 0);
    chk("reset_grant", grant, 0);
    rst = 1'b0;
    // single request
    @(negedge clk);
    req = 4'b0100; port_en = 4'b1111; req_frame[2*D +: D] = 16'hA5C3;
    @(negedge clk);
    chk("single_grant", grant, 4'b0100);
    chk("single_ftv", ftv, 1);
    chk("single_frame", tx_frame, 16'hA5C3);
    chk("single_last", last_grant, 2);
    chk("single_count", tx_count, 1);
    req = '0;
    repeat (18) @(negedge clk);
    chk("single_busy_c19", busy, 1);
    @(negedge clk);
    chk("single_busy_c20", busy, 0);
    // full round-robin from a fresh pointer, then wrap with 1010
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) req_frame[i*D +: D] = D'(16'h1100 * (i + 1));
    req = 4'b1111;
    for (int c = 1; c <= 161; c++) begin
      @(negedge clk);
      if (c % 20 == 1) begin
        chk("rr_ftv", ftv, 1);
        chk("rr_grant", grant, 64'(N'(1) << exp_g[c/20]));
        if (c / 20 < 5) chk("sat_count", tx_count2, exp_sat[c/20]);
      end
      if (c == 141) req = 4'b1010;
    end
    req = '0;
    repeat (20) @(negedge clk);
    // masking
    req = 4'b0100; port_en = 4'b1011;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("mask_grant", grant, 0);
      chk("mask_busy", busy, 0);
      if (c == 10) port_en = 4'b1111;
    end
    @(negedge clk);
    chk("unmask_grant", grant, 4'b0100);
    req = '0;
    // reset mid-frame
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_frame", tx_frame, 0);
    chk("rst_count", tx_count, 0);
    chk("rst_last", last_grant, 0);
    @(negedge clk);
    rst = 1'b0; req = 4'b1001;
    @(negedge clk);
    chk("post_rst_grant", grant, 4'b0001);
    // randomized run
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) req_frame[i*D +: D] = D'($urandom);
        req[i] = ($urandom_range(0, 3) != 0) ? req[i] | ($urandom_range(0, 2) == 0) : 1'b0;
        port_en[i] = ($urandom_range(0, 5) != 0);
      end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
